mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS controller FSM; drives datapath enables/selects per instruction step.
- Decodes opcode/funct once per instruction; no longer one decode per instruction-per-cycle.
- Adds a memory handshake so fetch/load/store stall on slow memory.
- Supports r-type (add/sub/and/or/slt), lw, sw, beq, addi, j.

---
 rtl/mips_mc_pkg.sv | 54 +++++
 rtl/mips_mc_aludec.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// values, ALUOp and alucontrol codes, and the datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_BRANCHNE,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps ALUOp (and funct for R-type) to the alucontrol code and
// flags funct values the datapath does not implement.
module mips_mc_aludec
  import mips_mc_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic [1:0]           aluop,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 funct_illegal
);

  always_comb begin
    alucontrol    = ALUCTRL_W'(ALU_ADD);
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_SUB: alucontrol = ALUCTRL_W'(ALU_SUB);
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_W'(FN_ADD): alucontrol = ALUCTRL_W'(ALU_ADD);
          FUNCT_W'(FN_SUB): alucontrol = ALUCTRL_W'(ALU_SUB);
          FUNCT_W'(FN_AND): alucontrol = ALUCTRL_W'(ALU_AND);
          FUNCT_W'(FN_OR):  alucontrol = ALUCTRL_W'(ALU_OR);
          FUNCT_W'(FN_SLT): alucontrol = ALUCTRL_W'(ALU_SLT);
          // Unknown funct keeps the add code so the ALU never sees an undefined op
          default:          funct_illegal = 1'b1;
        endcase
      end
      default: alucontrol = ALUCTRL_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller FSM with a memory-ready handshake on fetch/load/store.
// Define MIPS_MC_BNE_EN to add bne (opcode 000101); otherwise bne is illegal.
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic                 PCEn,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 instr_done,
  output logic                 illegal_op
);

  state_t state, state_nx;

  logic                 op_rtype, op_lw, op_sw, op_beq, op_bne, op_addi, op_j, op_legal;
  logic                 is_lw_q;
  logic [1:0]           aluop;
  logic [ALUCTRL_W-1:0] alu_dec;
  logic                 funct_illegal;
  logic                 pcwrite, branch, branchne;

  assign op_rtype = (opcode == OP_W'(OP_RTYPE));
  assign op_lw    = (opcode == OP_W'(OP_LW));
  assign op_sw    = (opcode == OP_W'(OP_SW));
  assign op_beq   = (opcode == OP_W'(OP_BEQ));
  assign op_addi  = (opcode == OP_W'(OP_ADDI));
  assign op_j     = (opcode == OP_W'(OP_J));
`ifdef MIPS_MC_BNE_EN
  assign op_bne   = (opcode == OP_W'(OP_BNE));
`else
  assign op_bne   = 1'b0;
`endif
  assign op_legal = op_rtype | op_lw | op_sw | op_beq | op_bne | op_addi | op_j;

  assign aluop = (state == S_EXECUTE) ? ALUOP_FUNCT :
                 ((state == S_BRANCH) || (state == S_BRANCHNE)) ? ALUOP_SUB : ALUOP_ADD;

  mips_mc_aludec #(
    .FUNCT_W   (FUNCT_W),
    .ALUCTRL_W (ALUCTRL_W)
  ) u_aludec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alu_dec),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nx;
  end

  // Load/store class is captured once in DECODE so MEMADR need not re-decode
  always_ff @(posedge clk) begin
    if (state == S_DECODE) is_lw_q <= op_lw;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        if (op_lw || op_sw)  state_nx = S_MEMADR;
        else if (op_rtype)   state_nx = S_EXECUTE;
        else if (op_beq)     state_nx = S_BRANCH;
        else if (op_bne)     state_nx = S_BRANCHNE;
        else if (op_addi)    state_nx = S_ADDIEX;
        else if (op_j)       state_nx = S_JUMP;
        else                 state_nx = S_FETCH;
      end
      S_MEMADR:  state_nx = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_nx = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_nx = S_FETCH;
      S_EXECUTE: state_nx = funct_illegal ? S_FETCH : S_ALUWB;
      S_ADDIEX:  state_nx = S_ADDIWB;
      default:   state_nx = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    PCSrc      = PC_ALURES;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMMSH;
        illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        illegal_op = funct_illegal;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        PCSrc      = PC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCHNE: begin
        ALUSrcA    = 1'b1;
        PCSrc      = PC_ALUOUT;
        branchne   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = PC_JUMP;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    PCEn = pcwrite | (branch & Zero) | (branchne & ~Zero);
    // Holding reset silences every strobe, including mid-instruction writes
    if (!reset_n) begin
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      PCEn       = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign alucontrol = reset_n ? alu_dec : '0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench: each instruction is expanded into its list of
// steps from the instruction rules, and every cycle's outputs are compared.
module tb_mips_multicycle_ctrl;

  localparam int OP_W = 6, FUNCT_W = 6, ALUCTRL_W = 3;

  localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_MEMRD = 3, K_MEMWB = 4,
                 K_MEMWR = 5, K_EXEC = 6, K_ALUWB = 7, K_BEQ = 8, K_BNE = 9,
                 K_AEX = 10, K_AWB = 11, K_JUMP = 12;

`ifdef MIPS_MC_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic [OP_W-1:0] opcode;
  logic [FUNCT_W-1:0] funct;
  logic Zero, mem_ready;
  logic mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic instr_done, illegal_op;
  logic [17:0] obs;

  int total = 0;
  int bad = 0;

  mips_multicycle_ctrl #(.OP_W(OP_W), .FUNCT_W(FUNCT_W), .ALUCTRL_W(ALUCTRL_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
    .alucontrol(alucontrol), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, PCEn, alucontrol, instr_done, illegal_op};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'd34:   return 3'b110;
      6'd36:   return 3'b000;
      6'd37:   return 3'b001;
      6'd42:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd8 ||
           op == 6'd2 || (op == 6'd5 && BNE_ON);
  endfunction

  // Cycles from fetch to the completion (or illegal) pulse with no memory stalls
  function automatic int lat_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0:    return funct_ok(fn) ? 4 : 3;
      6'd35:   return 5;
      6'd43:   return 4;
      6'd4:    return 3;
      6'd8:    return 4;
      6'd2:    return 3;
      6'd5:    return BNE_ON ? 3 : 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [17:0] model_out(input int k, input logic mr, input logic z,
                                            input logic [5:0] op, input logic [5:0] fn);
    logic mreq, iord, mwr, irw, rdst, m2r, rw, sa, pcen, done, ill;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    {mreq, iord, mwr, irw, rdst, m2r, rw, sa, pcen, done, ill} = '0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (k)
      K_FETCH:  begin mreq = 1; sb = 2'b01; irw = mr; pcen = mr; end
      K_DECODE: begin sb = 2'b11; ill = !legal_op(op); end
      K_MEMADR: begin sa = 1; sb = 2'b10; end
      K_MEMRD:  begin mreq = 1; iord = 1; end
      K_MEMWB:  begin m2r = 1; rw = 1; done = 1; end
      K_MEMWR:  begin mreq = 1; iord = 1; mwr = 1; done = mr; end
      K_EXEC:   begin sa = 1; alu = funct_alu(fn); ill = !funct_ok(fn); end
      K_ALUWB:  begin rdst = 1; rw = 1; done = 1; end
      K_BEQ:    begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = z; done = 1; end
      K_BNE:    begin sa = 1; alu = 3'b110; pcs = 2'b01; pcen = !z; done = 1; end
      K_AEX:    begin sa = 1; sb = 2'b10; end
      K_AWB:    begin rw = 1; done = 1; end
      K_JUMP:   begin pcs = 2'b10; pcen = 1; done = 1; end
      default:  ;
    endcase
    return {mreq, iord, mwr, irw, rdst, m2r, rw, sa, sb, pcs, pcen, alu, done, ill};
  endfunction

  // One clock cycle: drive inputs just after the edge, sample at the falling edge
  task automatic step_cycle(input int k, input logic mr, input logic z, input logic [5:0] op,
                            input logic [5:0] fn, input string tag, output logic saw_done);
    opcode    = (k == K_FETCH) ? 6'($urandom) : op;
    funct     = (k == K_FETCH) ? 6'($urandom) : fn;
    mem_ready = mr;
    Zero      = z;
    @(negedge clk);
    check_val(tag, 32'(obs), 32'(model_out(k, mr, z, op, fn)));
    saw_done = instr_done | illegal_op;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                           input int mstall, input int zsel, input string tag);
    int steps[$];
    int cyc, stalls, done_cyc, n;
    bit is_mem;
    logic mr, z, d;
    case (op)
      6'd0:    steps = funct_ok(fn) ? '{K_FETCH, K_DECODE, K_EXEC, K_ALUWB}
                                    : '{K_FETCH, K_DECODE, K_EXEC};
      6'd35:   steps = '{K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB};
      6'd43:   steps = '{K_FETCH, K_DECODE, K_MEMADR, K_MEMWR};
      6'd4:    steps = '{K_FETCH, K_DECODE, K_BEQ};
      6'd8:    steps = '{K_FETCH, K_DECODE, K_AEX, K_AWB};
      6'd2:    steps = '{K_FETCH, K_DECODE, K_JUMP};
      6'd5:    steps = BNE_ON ? '{K_FETCH, K_DECODE, K_BNE} : '{K_FETCH, K_DECODE};
      default: steps = '{K_FETCH, K_DECODE};
    endcase
    cyc = 0; stalls = 0; done_cyc = 0;
    foreach (steps[i]) begin
      is_mem = steps[i] == K_FETCH || steps[i] == K_MEMRD || steps[i] == K_MEMWR;
      n = 0;
      for (int guard = 0; guard < 16; guard++) begin
        if (!is_mem) mr = 1'($urandom);
        else if ((steps[i] == K_FETCH ? fstall : mstall) < 0) mr = ($urandom % 3 != 0) || n >= 4;
        else mr = n >= (steps[i] == K_FETCH ? fstall : mstall);
        z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        cyc++;
        step_cycle(steps[i], mr, z, op, fn, tag, d);
        if (d && done_cyc == 0) done_cyc = cyc;
        if (!is_mem || mr) break;
        stalls++;
        n++;
      end
    end
    check_val({tag, "_lat"}, 32'(done_cyc), 32'(lat_of(op, fn) + stalls));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic d;
    logic [5:0] op, fn;
    int r;
    reset_n = 1'b0; opcode = '0; funct = '0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_val("reset", 32'(obs), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset asserted for two cycles while a load waits in MEMRD
    step_cycle(K_FETCH, 1, 0, 6'd35, 6'd0, "rst_pre", d);
    step_cycle(K_DECODE, 0, 0, 6'd35, 6'd0, "rst_pre", d);
    step_cycle(K_MEMADR, 0, 0, 6'd35, 6'd0, "rst_pre", d);
    step_cycle(K_MEMRD, 0, 0, 6'd35, 6'd0, "rst_pre", d);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'($urandom); Zero = 1'($urandom);
      @(negedge clk);
      check_val("rst_mid", 32'(obs), 32'd0);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    step_cycle(K_FETCH, 0, 0, 6'd0, 6'd0, "rst_fetch", d);
    run_instr(6'd43, 6'd0, 0, 0, -1, "sw_after_rst");

    run_instr(6'd0, 6'b100000, 0, 0, -1, "add");
    run_instr(6'd0, 6'b100010, 0, 0, -1, "sub");
    run_instr(6'd0, 6'b100100, 0, 0, -1, "and");
    run_instr(6'd0, 6'b100101, 0, 0, -1, "or");
    run_instr(6'd0, 6'b101010, 0, 0, -1, "slt");
    run_instr(6'd35, 6'd0, 0, 3, -1, "lw_stall3");
    run_instr(6'd43, 6'd0, 2, 2, -1, "sw_stall");
    run_instr(6'd4, 6'd0, 0, 0, 1, "beq_z1");
    run_instr(6'd4, 6'd0, 0, 0, 0, "beq_z0");
    run_instr(6'b111111, 6'd0, 0, 0, -1, "ill_op");
    run_instr(6'd0, 6'b000111, 0, 0, -1, "ill_fn");
    run_instr(6'd8, 6'd0, 0, 0, -1, "addi");
    run_instr(6'd2, 6'd0, 0, 0, -1, "j");
    run_instr(6'd5, 6'd0, 0, 0, 0, "bne_z0");
    run_instr(6'd5, 6'd0, 0, 0, 1, "bne_z1");

    for (int t = 0; t < 200; t++) begin
      r = int'($urandom % 8);
      fn = 6'($urandom);
      case (r)
        0: begin
          op = 6'd0;
          if ($urandom % 5 != 0) begin
            case ($urandom % 5)
              0: fn = 6'd32;
              1: fn = 6'd34;
              2: fn = 6'd36;
              3: fn = 6'd37;
              default: fn = 6'd42;
            endcase
          end
        end
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd8;
        5: op = 6'd2;
        6: op = 6'd5;
        default: op = 6'($urandom);
      endcase
      run_instr(op, fn, -1, -1, -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
